// File: rtl/fetch_pkg.sv
// Shared fetch-stage types, constants and parameter checks for the instruction memory
// pipeline.
package fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_resp_t;

  function automatic bit latency_ok(int unsigned latency);
    return (latency == 1) || (latency == 2);
  endfunction

  function automatic bit depth_ok(int unsigned depth);
    return (depth >= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write / single-read synchronous RAM. A read and a write to the same word in one
// cycle return the old contents.
module imem_ram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_pipe.sv
// Pipelined instruction memory for the IF stage: valid/ready fetch, downstream stall,
// branch flush, fault detection and a program-load write port.
module imem_pipe
  import fetch_pkg::fetch_resp_t;
  import fetch_pkg::latency_ok;
  import fetch_pkg::depth_ok;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_pc,
  output logic                     resp_valid,
  input  logic                     resp_stall,
  output logic [31:0]              resp_instr,
  output logic [31:0]              resp_pc,
  output logic                     resp_fault,
  input  logic                     flush,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!latency_ok(LATENCY)) begin : gen_bad_latency
    $error("imem_pipe: LATENCY must be 1 or 2, got %0d", LATENCY);
  end

  if (!depth_ok(DEPTH)) begin : gen_bad_depth
    $error("imem_pipe: DEPTH must be a power of two >= 16, got %0d", DEPTH);
  end

  fetch_resp_t resp;

  logic        stalled;
  logic        advance;
  logic        accept;
  logic        req_fault;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign stalled   = resp.valid && resp_stall;
  // Flush overrides stall so the redirect target is taken in the same cycle.
  assign advance   = flush || !stalled;
  assign req_ready = advance;
  assign accept    = req_valid && advance;

  // Misaligned or beyond the array; no wrap-around.
  assign req_fault = (req_pc[1:0] != 2'b00) || (req_pc[31:AW+2] != '0);
  assign ram_re    = accept && !req_fault;

  imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (req_pc[AW+1:2]),
    .rdata (ram_rdata),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_data)
  );

  // Stage 1: control fields alongside the RAM output register.
  logic        s1_valid_q, s1_valid_d;
  logic        s1_fault_q, s1_fault_d;
  logic [31:0] s1_pc_q, s1_pc_d;
  logic [31:0] s1_instr;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fault_d = s1_fault_q;
    s1_pc_d    = s1_pc_q;
    if (advance) begin
      s1_valid_d = accept;
      s1_fault_d = req_fault;
      s1_pc_d    = req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fault_q <= 1'b0;
      s1_pc_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fault_q <= s1_fault_d;
      s1_pc_q    <= s1_pc_d;
    end
  end

  assign s1_instr = (s1_valid_q && !s1_fault_q) ? ram_rdata : NOP_INSTR;

  if (LATENCY == 1) begin : gen_lat1
    assign resp = '{valid: s1_valid_q, pc: s1_pc_q, instr: s1_instr, fault: s1_fault_q};
  end else begin : gen_lat2
    fetch_resp_t s2_q, s2_d;

    always_comb begin
      s2_d = s2_q;
      if (flush) begin
        s2_d.valid = 1'b0;
      end else if (!stalled) begin
        s2_d = '{valid: s1_valid_q, pc: s1_pc_q, instr: s1_instr, fault: s1_fault_q};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR, fault: 1'b0};
      end else begin
        s2_q <= s2_d;
      end
    end

    assign resp = s2_q;
  end

  assign resp_valid = resp.valid;
  assign resp_instr = resp.valid ? resp.instr : NOP_INSTR;
  assign resp_pc    = resp.pc;
  assign resp_fault = resp.valid && resp.fault;

endmodule
